// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl: store buffer that lane-aligns pipeline stores and drains them in FIFO order to data memory.
`ifndef SLWORD
`define SLWORD      3'd0
`define SLHALF      3'd1
`define SLBYTE      3'd2
`define SLWORDLEFT  3'd3
`define SLWORDRIGHT 3'd4
`endif
module store_drain_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_ctrl,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0] be_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] head, tail;
  logic [AW:0] count, count_next;
  logic [1:0] b;
  logic [31:0] cdata;
  logic [3:0] cbe;
  logic ok, push, pop, send, unused;
  assign b = st_addr[1:0];
  always_comb begin
    cdata = st_data;
    cbe = 4'b1111;
    ok = 1'b1;
    case (st_ctrl)
      `SLWORD: ;
      `SLHALF: begin
        cdata = st_data << {b[1], 4'b0000};
        cbe = b[1] ? 4'b1100 : 4'b0011;
      end
      `SLBYTE: begin
        cdata = st_data << {b, 3'b000};
        cbe = 4'b0001 << b;
      end
      `SLWORDLEFT: begin
        cdata = st_data >> {~b, 3'b000};
        cbe = 4'b1111 >> ~b;
      end
      `SLWORDRIGHT: begin
        cdata = st_data << {b, 3'b000};
        cbe = 4'b1111 << b;
      end
      default: ok = 1'b0;
    endcase
  end
  assign st_ready = count != FULL;
  assign sb_count = count;
  assign sb_empty = count == '0;
  assign send = state == SEND;
  assign push = st_valid && st_ready && ok;
  assign pop = send && mem_ack;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign mem_req = send;
  assign mem_addr = send ? {addr_q[head], 2'b00} : 32'd0;
  assign mem_wdata = send ? data_q[head] : 32'd0;
  assign mem_be = send ? be_q[head] : 4'd0;
  assign unused = ^ld_addr[1:0];
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) ld_hit = ld_hit | (vld[i] && addr_q[i] == ld_addr[31:2]);
  end
  // Entry payload needs no reset: vld gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr[31:2];
      data_q[tail] <= cdata;
      be_q[tail] <= cbe;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail <= tail + AW'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head <= head + AW'(1);
      end
      count <= count_next;
      // Leave IDLE only on the edge after the buffer is seen non-empty.
      state <= send ? (count_next != '0 ? SEND : IDLE) : (count != '0 ? SEND : IDLE);
    end
  end
endmodule

// File: tb/tb_store_drain_ctrl.sv
// tb_store_drain_ctrl: directed and random stimulus against a queue-based model of the store buffer.
module tb_store_drain_ctrl;
  localparam int DEPTH = 4;
  localparam logic [2:0] SLWORD = 3'd0, SLHALF = 3'd1, SLBYTE = 3'd2, SLWL = 3'd3, SLWR = 3'd4;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
  logic clk = 0, reset = 0, st_valid = 0, mem_ack = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [2:0] st_ctrl = 0;
  logic st_ready, mem_req, ld_hit, sb_empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [2:0] sb_count;
  int tests = 0, fails = 0;
  ent_t q[$];
  bit exp_req = 0;
  int prev_size = 0;
  logic [31:0] dat [4];
  store_drain_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_ctrl(st_ctrl), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .sb_count(sb_count), .sb_empty(sb_empty)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic ent_t conv(input logic [31:0] a, input logic [31:0] d, input logic [2:0] k, output bit ok);
    ent_t e;
    int b;
    b = int'(a[1:0]);
    ok = 1;
    e.a = {a[31:2], 2'b00};
    e.d = 0;
    e.be = 0;
    case (k)
      SLWORD: begin e.d = d; e.be = 4'hF; end
      SLHALF: begin e.d = d << (16 * (b / 2)); e.be = (b >= 2) ? 4'hC : 4'h3; end
      SLBYTE: begin e.d = d << (8 * b); e.be = 4'((1 << b)); end
      SLWL: begin e.d = d >> (8 * (3 - b)); e.be = 4'((1 << (b + 1)) - 1); end
      SLWR: begin e.d = d << (8 * b); e.be = 4'((15 << b) & 15); end
      default: ok = 0;
    endcase
    return e;
  endfunction
  task automatic cycle(input bit v, input logic [2:0] k, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] la, input bit ack);
    ent_t e;
    bit ok, push, pop, hit;
    @(negedge clk);
    st_valid = v; st_ctrl = k; st_addr = a; st_data = d; ld_addr = la; mem_ack = ack;
    #1;
    exp_req = q.size() > 0 && (exp_req || prev_size > 0);
    hit = 0;
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) hit = 1;
    check("st_ready", st_ready, q.size() < DEPTH);
    check("sb_count", sb_count, q.size());
    check("sb_empty", sb_empty, q.size() == 0);
    check("mem_req", mem_req, exp_req);
    check("mem_addr", mem_addr, exp_req ? q[0].a : 0);
    check("mem_wdata", mem_wdata, exp_req ? q[0].d : 0);
    check("mem_be", mem_be, exp_req ? q[0].be : 0);
    check("ld_hit", ld_hit, hit);
    e = conv(a, d, k, ok);
    push = v && ok && q.size() < DEPTH;
    pop = exp_req && ack;
    prev_size = q.size();
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
  endtask
  task automatic idle(input bit ack);
    cycle(0, SLWORD, 0, 0, 32'hFFFF_FFF0, ack);
  endtask
  initial begin
    #2;
    check("rst_req", mem_req, 0);
    check("rst_empty", sb_empty, 1);
    check("rst_ready", st_ready, 1);
    check("rst_count", sb_count, 0);
    @(negedge clk); reset = 1;
    cycle(1, SLBYTE, 32'h0000_1002, 32'h0000_00AB, 0, 1);
    idle(1);
    #1;
    check("byte_req", mem_req, 1);
    check("byte_addr", mem_addr, 32'h0000_1000);
    check("byte_wdata", mem_wdata, 32'h00AB_0000);
    check("byte_be", mem_be, 4'b0100);
    idle(1);
    #1 check("byte_empty", sb_empty, 1);
    cycle(1, SLWL, 32'h0000_3001, 32'h1122_3344, 0, 0);
    cycle(1, SLWR, 32'h0000_3001, 32'h1122_3344, 0, 0);
    #1;
    check("wl_wdata", mem_wdata, 32'h0000_1122);
    check("wl_be", mem_be, 4'b0011);
    idle(1);
    #1;
    check("wr_wdata", mem_wdata, 32'h2233_4400);
    check("wr_be", mem_be, 4'b1110);
    idle(1);
    idle(0);
    for (int i = 0; i < 4; i++) begin
      dat[i] = $urandom;
      cycle(1, SLWORD, 32'h0000_4000 + 32'(4 * i), dat[i], 0, 0);
    end
    #1;
    check("full_ready", st_ready, 0);
    check("full_count", sb_count, 4);
    cycle(1, SLWORD, 32'h0000_4100, 32'hDEAD_BEEF, 0, 0);
    #1 check("full_hold", sb_count, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_req", mem_req, 1);
      check("drain_data", mem_wdata, dat[i]);
      idle(1);
    end
    idle(0);
    cycle(1, SLWORD, 32'h0000_6000, $urandom, 0, 0);
    cycle(1, SLWORD, 32'h0000_6004, $urandom, 0, 0);
    idle(0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, SLHALF, 32'h0000_6010 + 32'(4 * i) + 32'(2 * (i % 2)), $urandom, 0, 1);
      #1 check("pp_count", sb_count, 2);
    end
    idle(1); idle(1); idle(1);
    cycle(1, SLWORD, 32'h0000_2004, 32'h1234_5678, 0, 0);
    #1;
    ld_addr = 32'h0000_2007;
    #1 check("hit_same", ld_hit, 1);
    ld_addr = 32'h0000_2008;
    #1 check("hit_next", ld_hit, 0);
    idle(1); idle(1);
    for (int i = 0; i < 3; i++) cycle(1, SLWORD, 32'h0000_7000 + 32'(4 * i), $urandom, 0, 0);
    idle(0);
    #1 check("pre_rst_req", mem_req, 1);
    @(negedge clk);
    ld_addr = 32'h0000_7000;
    reset = 0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_count", sb_count, 0);
    check("mid_rst_empty", sb_empty, 1);
    check("mid_rst_ready", st_ready, 1);
    check("mid_rst_hit", ld_hit, 0);
    q.delete();
    exp_req = 0;
    prev_size = 0;
    @(negedge clk); reset = 1;
    for (int i = 0; i < 4; i++) idle(1);
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 32'h0000_5000 + 32'($urandom_range(0, 31)),
            $urandom, 32'h0000_5000 + 32'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
